// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel (AR + R) between the
// I-cache and D-cache refill engines; one INCR burst per granted request.
module axi_read_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32,
    parameter int BEATS  = 16
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              i_i_req,
    input  logic [ADDR_W-1:0] i_i_addr,
    input  logic              i_d_req,
    input  logic [ADDR_W-1:0] i_d_addr,
    output logic              o_i_rvalid,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_i_done,
    output logic              o_d_done,
    output logic              o_err,
    output logic              o_ar_valid,
    input  logic              i_ar_ready,
    output logic [ADDR_W-1:0] o_ar_addr,
    output logic [7:0]        o_ar_len,
    output logic [2:0]        o_ar_size,
    output logic [1:0]        o_ar_burst,
    input  logic              i_r_valid,
    input  logic [DATA_W-1:0] i_r_data,
    input  logic              i_r_last,
    input  logic [1:0]        i_r_resp,
    output logic              o_r_ready
);

    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t             state, state_nx;
    logic               owner_d, owner_d_nx;
    logic [ADDR_W-1:0]  addr_q, addr_nx;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;
    logic               err_q, err_nx;
    logic               prio_d, prio_d_nx;
    logic               grant_d;
    logic               resp_bad;

    always_ff @(posedge clk) begin
        if (srst) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            prio_d  <= 1'b1;
        end else begin
            state   <= state_nx;
            owner_d <= owner_d_nx;
            addr_q  <= addr_nx;
            cnt_q   <= cnt_nx;
            err_q   <= err_nx;
            prio_d  <= prio_d_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        owner_d_nx = owner_d;
        addr_nx    = addr_q;
        cnt_nx     = cnt_q;
        err_nx     = err_q;
        prio_d_nx  = prio_d;
        grant_d    = 1'b0;
        resp_bad   = (i_r_resp != 2'b00);
        o_i_rvalid = 1'b0;
        o_d_rvalid = 1'b0;
        o_rdata    = '0;
        o_i_done   = 1'b0;
        o_d_done   = 1'b0;
        o_err      = 1'b0;
        o_ar_valid = 1'b0;
        o_ar_addr  = '0;
        o_ar_len   = '0;
        o_ar_size  = '0;
        o_ar_burst = '0;
        o_r_ready  = 1'b0;

        case (state)
            IDLE: begin
                // The loser of this grant becomes the preferred requester next time.
                if (i_i_req || i_d_req) begin
                    grant_d    = i_d_req && (!i_i_req || prio_d);
                    owner_d_nx = grant_d;
                    addr_nx    = grant_d ? i_d_addr : i_i_addr;
                    prio_d_nx  = !grant_d;
                    state_nx   = ADDR;
                end
            end
            ADDR: begin
                o_ar_valid = 1'b1;
                o_ar_addr  = addr_q & ADDR_MASK;
                o_ar_len   = 8'(BEATS - 1);
                o_ar_size  = 3'($clog2(DATA_W / 8));
                o_ar_burst = 2'b01;
                if (i_ar_ready) begin
                    cnt_nx   = '0;
                    err_nx   = 1'b0;
                    state_nx = DATA;
                end
            end
            DATA: begin
                o_r_ready = 1'b1;
                if (i_r_valid) begin
                    o_rdata    = i_r_data;
                    o_i_rvalid = !owner_d;
                    o_d_rvalid = owner_d;
                    // Saturating so an overlong burst can never wrap back to LAST_CNT.
                    if (cnt_q != CNT_MAX) begin
                        cnt_nx = cnt_q + CNT_W'(1);
                    end
                    if (resp_bad) begin
                        err_nx = 1'b1;
                    end
                    if (i_r_last) begin
                        o_i_done = !owner_d;
                        o_d_done = owner_d;
                        o_err    = err_q || resp_bad || (cnt_q != LAST_CNT);
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Table-driven bench for axi_read_arbiter: cycle vectors with hand-computed
// expectations, plus a hand-written AR-stall / sparse-R-valid sequence.
module tb_axi_read_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;
    localparam int BEATS  = 16;

    localparam logic [63:0] I_ADDR = 64'h0000_0000_8000_0024;
    localparam logic [63:0] I_BLK  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] D_ADDR = 64'h0000_1234_5678_9ABC;
    localparam logic [63:0] D_BLK  = 64'h0000_1234_5678_9A80;

    logic              clk = 1'b0;
    logic              srst = 1'b1;
    logic              i_i_req = 1'b0;
    logic [ADDR_W-1:0] i_i_addr = I_ADDR;
    logic              i_d_req = 1'b0;
    logic [ADDR_W-1:0] i_d_addr = D_ADDR;
    logic              o_i_rvalid, o_d_rvalid;
    logic [DATA_W-1:0] o_rdata;
    logic              o_i_done, o_d_done, o_err;
    logic              o_ar_valid;
    logic              i_ar_ready = 1'b0;
    logic [ADDR_W-1:0] o_ar_addr;
    logic [7:0]        o_ar_len;
    logic [2:0]        o_ar_size;
    logic [1:0]        o_ar_burst;
    logic              i_r_valid = 1'b0;
    logic [DATA_W-1:0] i_r_data = '0;
    logic              i_r_last = 1'b0;
    logic [1:0]        i_r_resp = 2'b00;
    logic              o_r_ready;

    int total = 0;
    int bad   = 0;

    axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk(clk), .srst(srst),
        .i_i_req(i_i_req), .i_i_addr(i_i_addr),
        .i_d_req(i_d_req), .i_d_addr(i_d_addr),
        .o_i_rvalid(o_i_rvalid), .o_d_rvalid(o_d_rvalid), .o_rdata(o_rdata),
        .o_i_done(o_i_done), .o_d_done(o_d_done), .o_err(o_err),
        .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready), .o_ar_addr(o_ar_addr),
        .o_ar_len(o_ar_len), .o_ar_size(o_ar_size), .o_ar_burst(o_ar_burst),
        .i_r_valid(i_r_valid), .i_r_data(i_r_data), .i_r_last(i_r_last),
        .i_r_resp(i_r_resp), .o_r_ready(o_r_ready)
    );

    always #5 clk = ~clk;

    // ectl packs {ar_valid, r_ready, i_rvalid, d_rvalid, i_done, d_done, err}.
    typedef struct {
        logic        chk;
        logic        srst;
        logic        ireq;
        logic        dreq;
        logic        arready;
        logic        rvalid;
        logic        rlast;
        logic [1:0]  rresp;
        logic [31:0] rdata;
        logic [6:0]  ectl;
        logic [63:0] earaddr;
        logic [31:0] erdata;
    } vec_t;

    vec_t tbl[$];

    task automatic add_row(input logic chk, input logic rst, input logic ireq, input logic dreq,
                           input logic arready, input logic rvalid, input logic rlast,
                           input logic [1:0] rresp, input logic [31:0] rdata,
                           input logic [6:0] ectl, input logic [63:0] earaddr,
                           input logic [31:0] erdata);
        vec_t v;
        v.chk = chk; v.srst = rst; v.ireq = ireq; v.dreq = dreq;
        v.arready = arready; v.rvalid = rvalid; v.rlast = rlast;
        v.rresp = rresp; v.rdata = rdata; v.ectl = ectl;
        v.earaddr = earaddr; v.erdata = erdata;
        tbl.push_back(v);
    endtask

    task automatic add_idle(input logic ireq, input logic dreq);
        add_row(1'b1, 1'b0, ireq, dreq, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 7'b0, 64'h0, 32'h0);
    endtask

    task automatic add_reset();
        add_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 7'b0, 64'h0, 32'h0);
    endtask

    // One ADDR cycle with immediate ar_ready, then nbeats back-to-back R beats.
    task automatic add_burst(input logic ireq, input logic dreq, input logic own_d,
                             input logic [63:0] blk, input int nbeats, input int bad_beat,
                             input logic exp_err);
        add_row(1'b1, 1'b0, ireq, dreq, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 7'b1000000, blk, 32'h0);
        for (int k = 1; k <= nbeats; k++) begin
            logic [31:0] d;
            logic        is_last;
            logic [6:0]  ectl;
            d       = {(own_d ? 16'hDDDD : 16'h1111), 16'(k)};
            is_last = (k == nbeats);
            ectl    = {1'b0, 1'b1, !own_d, own_d, is_last && !own_d, is_last && own_d,
                       is_last && exp_err};
            add_row(1'b1, 1'b0, ireq, dreq, 1'b0, 1'b1, is_last,
                    (k == bad_beat) ? 2'b10 : 2'b00, d, ectl, 64'h0, d);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        srst       = v.srst;
        i_i_req    = v.ireq;
        i_d_req    = v.dreq;
        i_ar_ready = v.arready;
        i_r_valid  = v.rvalid;
        i_r_last   = v.rlast;
        i_r_resp   = v.rresp;
        i_r_data   = v.rdata;
        #1;
    endtask

    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_output(input vec_t v, input int idx);
        logic [115:0] act, exp;
        act = {o_ar_valid, o_r_ready, o_i_rvalid, o_d_rvalid, o_i_done, o_d_done, o_err,
               o_ar_addr, o_ar_len, o_ar_size, o_ar_burst, o_rdata};
        exp = {v.ectl, (v.ectl[6] ? v.earaddr : 64'h0), (v.ectl[6] ? 8'd15 : 8'd0),
               (v.ectl[6] ? 3'd2 : 3'd0), (v.ectl[6] ? 2'd1 : 2'd0), v.erdata};
        check_val($sformatf("row%0d", idx), 128'(act), 128'(exp));
    endtask

    // ar_ready held low 5 cycles, then R valid only on every other cycle.
    task automatic run_stall();
        int   beats;
        logic finished;
        logic [88:0] ar_exp;
        ar_exp = {1'b1, I_BLK, 8'd15, 3'd2, 2'd1, 1'b0, 8'h0};
        @(negedge clk);
        i_i_req = 1'b1; i_d_req = 1'b0; i_ar_ready = 1'b0; i_r_valid = 1'b0; i_r_last = 1'b0;
        #1;
        check_val("stall_idle_arvalid", 128'(o_ar_valid), 128'(0));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            i_ar_ready = (c == 5);
            #1;
            check_val($sformatf("stall_ar_c%0d", c),
                      128'({o_ar_valid, o_ar_addr, o_ar_len, o_ar_size, o_ar_burst, o_r_ready, 8'h0}),
                      128'(ar_exp));
        end
        beats    = 0;
        finished = 1'b0;
        for (int c = 0; c < 60 && !finished; c++) begin
            logic v;
            @(negedge clk);
            i_ar_ready = 1'b0;
            v          = (c % 2 == 1);
            i_r_valid  = v;
            i_r_last   = v && (beats == 15);
            i_r_data   = 32'h5A00_0000 + 32'(beats + 1);
            #1;
            check_val($sformatf("stall_r_c%0d", c),
                      128'({o_r_ready, o_i_rvalid, o_d_rvalid, o_i_done, o_d_done, o_err}),
                      128'({1'b1, v, 1'b0, v && (beats == 15), 1'b0, 1'b0}));
            if (o_i_rvalid) beats++;
            if (o_i_done) finished = 1'b1;
        end
        check_val("stall_beat_count", 128'(beats), 128'(16));
        check_val("stall_done_seen", 128'(finished), 128'(1));
        @(negedge clk);
        i_i_req = 1'b0; i_r_valid = 1'b0; i_r_last = 1'b0;
        #1;
        check_val("stall_back_idle",
                  128'({o_ar_valid, o_r_ready, o_i_rvalid, o_d_rvalid, o_i_done, o_d_done, o_err}),
                  128'(0));
    endtask

    initial begin
        // reset and single I-cache refill
        add_row(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 7'b0, 64'h0, 32'h0);
        add_reset();
        add_idle(1'b1, 1'b0);
        add_burst(1'b1, 1'b0, 1'b0, I_BLK, 16, 0, 1'b0);
        add_idle(1'b0, 1'b0);
        // both requesting after reset: D, I, D, I with one idle cycle between
        add_reset();
        add_idle(1'b1, 1'b1);
        add_burst(1'b1, 1'b1, 1'b1, D_BLK, 16, 0, 1'b0);
        add_idle(1'b1, 1'b1);
        add_burst(1'b1, 1'b1, 1'b0, I_BLK, 16, 0, 1'b0);
        add_idle(1'b1, 1'b1);
        add_burst(1'b1, 1'b1, 1'b1, D_BLK, 16, 0, 1'b0);
        add_idle(1'b1, 1'b1);
        add_burst(1'b1, 1'b1, 1'b0, I_BLK, 16, 0, 1'b0);
        add_idle(1'b0, 1'b0);
        // error response on beat 7
        add_idle(1'b0, 1'b1);
        add_burst(1'b0, 1'b1, 1'b1, D_BLK, 16, 7, 1'b1);
        add_idle(1'b0, 1'b0);
        // early rlast on beat 12
        add_idle(1'b1, 1'b0);
        add_burst(1'b1, 1'b0, 1'b0, I_BLK, 12, 0, 1'b1);
        add_idle(1'b0, 1'b0);
        // overlong burst, rlast on beat 18
        add_idle(1'b0, 1'b1);
        add_burst(1'b0, 1'b1, 1'b1, D_BLK, 18, 0, 1'b1);
        add_idle(1'b0, 1'b0);
        // srst on beat 5 of a D refill, then a fresh I refill
        add_idle(1'b0, 1'b1);
        add_row(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 7'b1000000, D_BLK, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            add_row(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'hC0DE_0000 + 32'(k),
                    7'b0101000, 64'h0, 32'hC0DE_0000 + 32'(k));
        end
        add_row(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'hC0DE_0005,
                7'b0101000, 64'h0, 32'hC0DE_0005);
        add_idle(1'b0, 1'b0);
        add_idle(1'b1, 1'b0);
        add_burst(1'b1, 1'b0, 1'b0, I_BLK, 16, 0, 1'b0);
        add_idle(1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i]);
            if (tbl[i].chk) check_output(tbl[i], i);
        end

        run_stall();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Arbitrates the instruction-cache refill and the data-cache refill onto the single AXI4 read channel (AR + R) of the core. It replaces the simple OR of the two start-read requests. It issues one INCR burst per granted request, steers returned beats to the owning cache and signals completion and error per transaction. It sits between the control unit's cache FSMs and the AXI master port.

## Interface
Parameters:
- ADDR_W, 64, address width.
- DATA_W, 32, R-channel data width in bits (power of two, ≥8).
- BEATS, 16, beats per cache-block burst (power of two, 1..256).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- srst  in  1  reset, synchronous, active-high.
- i_i_req  in  1  I-cache refill request. Level; held until o_i_done.
- i_i_addr  in  ADDR_W  I-cache miss address.
- i_d_req  in  1  D-cache refill request. Level; held until o_d_done.
- i_d_addr  in  ADDR_W  D-cache miss address.
- o_i_rvalid, o_d_rvalid  out  1 each  beat valid for the owning cache.
- o_rdata  out  DATA_W  beat data (shared; qualified by the rvalid signals).
- o_i_done, o_d_done  out  1 each  one-cycle pulse on the final beat of a transaction.
- o_err  out  1  one-cycle pulse with done if the transaction had an error.
- o_ar_valid  out  1  AXI AR valid.
- i_ar_ready  in  1  AXI AR ready.
- o_ar_addr  out  ADDR_W  AXI AR address.
- o_ar_len  out  8  AXI AR length.
- o_ar_size  out  3  AXI AR size.
- o_ar_burst  out  2  AXI AR burst type.
- i_r_valid  in  1  AXI R valid.
- i_r_data  in  DATA_W  AXI R data.
- i_r_last  in  1  AXI R last.
- i_r_resp  in  2  AXI R response.
- o_r_ready  out  1  AXI R ready.

## Operation
- States: IDLE, ADDR, DATA. Registers:
  - owner (I/D)
  - latched address
  - beat counter, $clog2(BEATS)+1 bits
  - error accumulator
  - prio bit (1 = D preferred)
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant per prio.
  - On a grant: latch owner and address, go to ADDR. prio is set to prefer the non-granted requester. This is round-robin between the two requesters.
- ADDR:
  - Outputs: o_ar_valid=1; o_ar_addr = latched address with the low $clog2(BEATS*DATA_W/8) bits cleared; o_ar_len=BEATS-1; o_ar_size=$clog2(DATA_W/8); o_ar_burst=2'b01.
  - AR outputs are stable until i_ar_ready.
  - On i_ar_valid&i_ar_ready: clear the counter and error accumulator, go to DATA.
- DATA:
  - o_r_ready=1.
  - Each R handshake (i_r_valid): the owner's rvalid=1 (combinational) and o_rdata=i_r_data. Increment the counter.
  - Set the error accumulator if i_r_resp≠2'b00.
  - Handshake with i_r_last: the owner's done=1. o_err = accumulator OR this beat's resp error OR counter≠BEATS-1. Go to IDLE.
  - Beats beyond BEATS without last: still accepted and forwarded, error flagged; the burst ends only on i_r_last.
- Requests are sampled only in IDLE. A request dropping mid-transaction does not abort the burst; done still pulses.
- A non-owner's rvalid and done stay 0 at all times.

## Timing
- Reset (srst sampled high): state=IDLE, prio=1 (D preferred), counter=0. All outputs 0, including o_rdata, o_ar_* and o_r_ready.
- srst mid-burst: the block returns to IDLE on the next edge. No done is pulsed. The AXI slave must be reset together with the block.
- Request high in IDLE at edge N: o_ar_valid=1 from cycle N+1.
- AR handshake at edge M: o_r_ready=1 from cycle M+1.
- Beat forwarding: zero latency, combinational from R inputs.
- After the last beat, IDLE lasts one cycle. A pending request gives o_ar_valid one cycle after that. Back-to-back gap: 1 idle cycle.
- A request asserted in the same cycle as done for the other requester is served next, via the IDLE arbitration.

## Test plan
- Single I-cache refill, addr 0x8000_0024, ar_ready immediate, 16 beats, no stalls:
  - o_ar_addr=0x8000_0000, len=15, size=2, burst=1.
  - o_i_rvalid 16 cycles, o_i_done on beat 16, o_err=0, o_d_* stay 0.
- Both requests in the same cycle after reset:
  - D served first, then I, with 1 IDLE cycle between bursts.
  - Repeat with both held: grants alternate D, I, D, I.
- ar_ready withheld 5 cycles, r_valid toggling every other cycle:
  - AR fields stable throughout.
  - Exactly 16 forwarded beats, done only on rlast.
- Beat 7 carries resp=2'b10: o_err=1 with done, data still forwarded.
- rlast on beat 12: burst ends, done with o_err=1.
- srst asserted on beat 5 of a D refill: next cycle state=IDLE, all outputs 0, no done. A fresh I request then completes normally.
